uart_rx_deser: RTL
==================

Name: uart_rx_deser

Overview:
- Simulation/bring-up UART receiver. Samples a serial RX line on the system clock and emits one byte per frame as a single-cycle valid strobe.
- Directly feeds the bench console print stage through `uart_data`/`uart_data_valid`.
- Fixed 8N1 framing (8 data bits, LSB first, no parity, 1 stop bit). Bit period is set in clocks by a parameter.
- Adds framing-error and break detection so corrupted frames never reach the print stage.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit; must be >= 4 (elaboration-time $error otherwise). HALF = CLKS_PER_BIT/2, integer division.
- TYPE, "generic", tag string used only in the simulation-only framing-error $display.

Ports:
- clk  input  1  system clock
- resetn  input  1  synchronous active-low reset
- rx  input  1  asynchronous serial line, idle high
- uart_data  output  8  received byte; held until the next valid frame
- uart_data_valid  output  1  one-cycle strobe; uart_data is valid in the same cycle
- frame_err  output  1  one-cycle strobe when the stop bit samples low
- rx_busy  output  1  high in any state other than IDLE

Behaviour:
- Interface: one clock, clk. Reset is resetn, synchronous and active-low, sampled only on posedge clk.
- Reset values:
  - 2-flop synchronizer rx_meta and rx_s reset to 1.
  - uart_data = 0, uart_data_valid = 0, frame_err = 0, rx_busy = 0.
  - State = ARM, cnt = 0, bitidx = 0, shift = 0.
- All logic uses rx_s only, never raw rx. rx_s lags rx by 2 cycles.
- cnt width is $clog2(CLKS_PER_BIT). bitidx is 3 bits.
- ARM: wait until rx_s == 1, then go to IDLE. This prevents a line held low across reset from being taken as a start bit.
- IDLE: when rx_s == 0, go to START with cnt <= 0.
- START: cnt increments each cycle. At cnt == HALF-1:
  - rx_s == 0: go to DATA, cnt <= 0, bitidx <= 0.
  - rx_s == 1: glitch; go to IDLE with no output.
- DATA: cnt increments. At cnt == CLKS_PER_BIT-1:
  - shift <= {rx_s, shift[7:1]} (LSB first), cnt <= 0.
  - If bitidx == 7, go to STOP; else bitidx++.
- STOP: at cnt == CLKS_PER_BIT-1:
  - rx_s == 1: uart_data <= shift, uart_data_valid <= 1 for exactly one cycle, go to IDLE.
  - rx_s == 0: frame_err <= 1 for one cycle, uart_data unchanged, no valid, go to BREAK.
- BREAK: stay until rx_s == 1, then go to IDLE. A long low line yields exactly one frame_err, with no further errors or bytes.
- Latency:
  - Mid-start sample occurs HALF-1 cycles after IDLE sees rx_s == 0.
  - Data bit k is sampled (k+1)*CLKS_PER_BIT cycles after mid-start.
  - Valid is registered 1 cycle after the stop sample.
- Back-to-back frames: a new start bit is accepted in the first IDLE cycle after valid. No dead time beyond that 1 cycle.
- uart_data_valid and frame_err are never high in the same cycle.
- rx_busy is combinational from state: high in START, DATA, STOP, BREAK; low in ARM and IDLE.
- Reset asserted mid-frame: the partial byte is discarded with no strobe, and the block re-enters ARM.
- Sim-only: on frame_err, $display("[%s] uart framing error", TYPE).

Test Plan:
- Byte 0x48 sent at exactly 16 clk/bit, idle high before and after → single valid pulse with uart_data = 0x48, 155±1 cycles after the rx falling edge; frame_err stays 0.
- "Hi\n" (0x48, 0x69, 0x0A) back-to-back, zero idle between stop and next start → three valid pulses carrying 0x48, 0x69, 0x0A in order, 160 cycles apart.
- 4-cycle low glitch on idle rx → no valid, no frame_err; rx_busy pulses high then returns to IDLE by cycle 8.
- Frame 0x55 with the stop bit driven low, then rx held low 100 bit times, then released → exactly one frame_err; uart_data keeps its previous value; the following good 0xA5 frame is received correctly.
- resetn asserted low for 1 cycle at the middle of bit 3 of 0xC3 → no strobe; next frame 0x3C is decoded correctly.
- rx held low through and after reset release for 50 cycles, then high, then 0x7E sent → no spurious byte; only 0x7E is delivered.

Source files
------------

// File: rtl/uart_rx_deser.sv
// uart_rx_deser: 8N1 UART receiver for simulation/bring-up consoles.
// Samples rx through a 2-flop synchronizer and emits one byte per frame.
// Ports:
//   clk             system clock
//   resetn          synchronous active-low reset
//   rx              asynchronous serial line, idle high
//   uart_data       last good byte, held until the next good frame
//   uart_data_valid one-cycle strobe, uart_data valid in the same cycle
//   frame_err       one-cycle strobe when the stop bit samples low
//   rx_busy         high whenever the receiver is not in ARM or IDLE
module uart_rx_deser #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter string       TYPE         = "generic"
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rx,
  output logic [7:0] uart_data,
  output logic       uart_data_valid,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int unsigned HALF  = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MID    = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_END    = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_SETTLE = CNT_W'(2);

  if (CLKS_PER_BIT < 4) begin : g_bad_param
    $error("uart_rx_deser: CLKS_PER_BIT must be >= 4");
  end

  typedef enum logic [2:0] {
    S_ARM,
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [2:0]       bitidx, bitidx_d;
  logic [7:0]       shift, shift_d;
  logic [7:0]       data_d;
  logic             valid_d, err_d;
  logic             rx_meta, rx_s;

  // Two-flop synchronizer; idles high so reset looks like an idle line.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state           <= S_ARM;
      cnt             <= '0;
      bitidx          <= '0;
      shift           <= '0;
      uart_data       <= '0;
      uart_data_valid <= 1'b0;
      frame_err       <= 1'b0;
    end else begin
      state           <= state_d;
      cnt             <= cnt_d;
      bitidx          <= bitidx_d;
      shift           <= shift_d;
      uart_data       <= data_d;
      uart_data_valid <= valid_d;
      frame_err       <= err_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    bitidx_d = bitidx;
    shift_d  = shift;
    data_d   = uart_data;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    unique case (state)
      S_ARM: begin
        // rx_s holds its reset value for two cycles; only trust it once the
        // synchronizer has flushed, so a line held low across reset is seen.
        if (cnt < CNT_SETTLE) begin
          cnt_d = cnt + CNT_W'(1);
        end else if (rx_s) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt == CNT_MID) begin
          cnt_d    = '0;
          bitidx_d = '0;
          state_d  = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt == CNT_END) begin
          shift_d = {rx_s, shift[7:1]};
          cnt_d   = '0;
          if (bitidx == 3'd7) state_d = S_STOP;
          else                bitidx_d = bitidx + 3'd1;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (cnt == CNT_END) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = shift;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      S_BREAK: begin
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_ARM;
    endcase
  end

  assign rx_busy = (state != S_ARM) && (state != S_IDLE);

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (frame_err) $display("[%s] uart framing error", TYPE);
  end
`endif

endmodule
